// File: rtl/vx_reset_sequencer_if.sv
// Reset-sequencer handshake bundle: soft-reset request in, domain resets,
// ready flag and soft-reset acknowledge out.
interface vx_reset_sequencer_if #(
  parameter int N = 4
);
  logic         soft_req;
  logic [N-1:0] reset_o;
  logic         ready;
  logic         soft_ack;

  // Requester side: raises soft_req, observes resets and completion.
  modport master (
    output soft_req,
    input  reset_o,
    input  ready,
    input  soft_ack
  );

  // Sequencer side: samples soft_req, drives resets and completion.
  modport slave (
    input  soft_req,
    output reset_o,
    output ready,
    output soft_ack
  );
endinterface

// File: rtl/vx_reset_sequencer.sv
// Reset sequencer: stretches the system reset for HOLD_CYCLES edges, then
// releases N active-high domain resets one at a time (domain 0 first),
// STAGE_DELAY edges apart. A soft-reset request seen while running restarts
// the whole sequence and is acknowledged with a one-cycle pulse on completion.
module vx_reset_sequencer #(
  parameter int N           = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_DELAY = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  vx_reset_sequencer_if.slave  rs
);

  localparam int MAX_CNT = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int SW      = $clog2(N + 1);

  localparam logic [CW-1:0] HOLD_END   = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] STAGE_END  = CW'(STAGE_DELAY);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [SW-1:0] STAGE_ZERO = SW'(0);
  localparam logic [SW-1:0] STAGE_ONE  = SW'(1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(N - 1);
  localparam logic [N-1:0]  ALL_ON     = {N{1'b1}};
  // With a single domain the end of HOLD is also the last release.
  localparam bit            SINGLE_DOM = (N == 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t        state_r,     state_s;
  logic [CW-1:0] cnt_r,       cnt_s;
  logic [SW-1:0] stage_r,     stage_s;     // index of the next domain to release
  logic [N-1:0]  reset_o_r,   reset_o_s;
  logic          ready_r,     ready_s;
  logic          soft_ack_r,  soft_ack_s;
  logic          soft_flag_r, soft_flag_s; // current sequence came from soft_req

  // Next-state and next-output logic; every output is computed here and registered.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    stage_s     = stage_r;
    reset_o_s   = reset_o_r;
    ready_s     = ready_r;
    soft_ack_s  = 1'b0;
    soft_flag_s = soft_flag_r;

    case (state_r)
      ST_HOLD: begin
        if (cnt_r == HOLD_END) begin
          // Thermometer shift: clears domain 0, higher domains stay in reset.
          reset_o_s = reset_o_r << 1'b1;
          cnt_s     = CNT_ONE;
          stage_s   = STAGE_ONE;
          if (SINGLE_DOM) begin
            state_s     = ST_RUN;
            ready_s     = 1'b1;
            soft_ack_s  = soft_flag_r;
            soft_flag_s = 1'b0;
          end else begin
            state_s = ST_RELEASE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      ST_RELEASE: begin
        if (cnt_r == STAGE_END) begin
          reset_o_s = reset_o_r << 1'b1;
          cnt_s     = CNT_ONE;
          stage_s   = stage_r + STAGE_ONE;
          if (stage_r == LAST_STAGE) begin
            state_s     = ST_RUN;
            ready_s     = 1'b1;
            soft_ack_s  = soft_flag_r;
            soft_flag_s = 1'b0;
          end else begin
            state_s = ST_RELEASE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      ST_RUN: begin
        // soft_req is only honoured here; elsewhere it is dropped, not queued.
        if (rs.soft_req) begin
          state_s     = ST_HOLD;
          cnt_s       = CNT_ZERO;
          stage_s     = STAGE_ZERO;
          reset_o_s   = ALL_ON;
          ready_s     = 1'b0;
          soft_flag_s = 1'b1;
        end else begin
          state_s = ST_RUN;
        end
      end

      default: begin
        state_s     = ST_HOLD;
        cnt_s       = CNT_ZERO;
        stage_s     = STAGE_ZERO;
        reset_o_s   = ALL_ON;
        ready_s     = 1'b0;
        soft_flag_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= ST_HOLD;
      cnt_r       <= CNT_ZERO;
      stage_r     <= STAGE_ZERO;
      reset_o_r   <= ALL_ON;
      ready_r     <= 1'b0;
      soft_ack_r  <= 1'b0;
      soft_flag_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      stage_r     <= stage_s;
      reset_o_r   <= reset_o_s;
      ready_r     <= ready_s;
      soft_ack_r  <= soft_ack_s;
      soft_flag_r <= soft_flag_s;
    end
  end

  assign rs.reset_o  = reset_o_r;
  assign rs.ready    = ready_r;
  assign rs.soft_ack = soft_ack_r;

endmodule

// File: tb/tb_vx_reset_sequencer.sv
// Bench for vx_reset_sequencer: a 4-domain instance (HOLD=16, STAGE=4) and a
// 1-domain instance (HOLD=1, STAGE=1) share clock and reset_n. Each cycle both
// are compared against a closed-form timing model of the release schedule.
module tb_vx_reset_sequencer;

  logic clk;
  logic reset_n;

  vx_reset_sequencer_if #(.N(4)) if_a ();
  vx_reset_sequencer_if #(.N(1)) if_b ();

  vx_reset_sequencer #(.N(4), .HOLD_CYCLES(16), .STAGE_DELAY(4)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .rs      (if_a)
  );

  vx_reset_sequencer #(.N(1), .HOLD_CYCLES(1), .STAGE_DELAY(1)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .rs      (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model parameters per instance.
  int m_n [2] = '{4, 1};
  int m_h [2] = '{16, 1};
  int m_s [2] = '{4, 1};
  // pos = edges since the trigger edge (trigger edge itself is pos 0).
  int m_pos  [2];
  bit m_flag [2];
  bit m_ack  [2];
  bit m_valid = 1'b0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Number of domains released pos edges after the trigger.
  function automatic int released(input int d, input int pos);
    int c;
    if (pos < 1 + m_h[d]) return 0;
    c = (pos - 1 - m_h[d]) / m_s[d] + 1;
    return (c > m_n[d]) ? m_n[d] : c;
  endfunction

  function automatic int exp_rst(input int d);
    int mask;
    mask = (1 << m_n[d]) - 1;
    return (mask << released(d, m_pos[d])) & mask;
  endfunction

  // Advance one instance's model across one clock edge.
  task automatic model_step(input int d, input bit rn, input bit sr);
    if (!rn) begin
      m_pos[d]  = 0;
      m_flag[d] = 1'b0;
      m_ack[d]  = 1'b0;
    end else if (released(d, m_pos[d]) == m_n[d]) begin
      if (sr) begin
        m_pos[d]  = 0;
        m_flag[d] = 1'b1;
      end
      m_ack[d] = 1'b0;
    end else begin
      m_pos[d]++;
      if (released(d, m_pos[d]) == m_n[d]) begin
        m_ack[d]  = m_flag[d];
        m_flag[d] = 1'b0;
      end else begin
        m_ack[d] = 1'b0;
      end
    end
  endtask

  function automatic bit is_therm(input logic [3:0] v);
    logic [3:0] ones;
    logic [3:0] t;
    ones = 4'hF;
    for (int k = 0; k <= 4; k++) begin
      t = ones << k;
      if (v == t) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Drive inputs, take one edge, update the model, compare on the falling edge.
  task automatic step(input bit rn, input bit sa, input bit sb);
    reset_n        = rn;
    if_a.soft_req  = sa;
    if_b.soft_req  = sb;
    @(posedge clk);
    model_step(0, rn, sa);
    model_step(1, rn, sb);
    if (!rn) m_valid = 1'b1;
    @(negedge clk);
    if (m_valid) begin
      check_eq("a_reset_o",  int'(if_a.reset_o),  exp_rst(0));
      check_eq("a_ready",    int'(if_a.ready),    int'(released(0, m_pos[0]) == 4));
      check_eq("a_soft_ack", int'(if_a.soft_ack), int'(m_ack[0]));
      check_eq("a_therm",    int'(is_therm(if_a.reset_o)), 1);
      check_eq("b_reset_o",  int'(if_b.reset_o),  exp_rst(1));
      check_eq("b_ready",    int'(if_b.ready),    int'(released(1, m_pos[1]) == 1));
      check_eq("b_soft_ack", int'(if_b.soft_ack), int'(m_ack[1]));
    end
  endtask

  initial begin
    int rise_a;
    int rise_b;
    int ack_a;
    int ack_b;
    reset_n       = 1'b0;
    if_a.soft_req = 1'b0;
    if_b.soft_req = 1'b0;

    // Hardware reset: 3 low cycles, then measure release latency from E0.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    check_eq("rst_reset_o", int'(if_a.reset_o), 4'hF);
    check_eq("rst_ready",   int'(if_a.ready),   0);
    rise_a = -1;
    rise_b = -1;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (if_a.ready && rise_a < 0) rise_a = i;
      if (if_b.ready && rise_b < 0) rise_b = i;
    end
    check_eq("hw_ready_lat_a", rise_a, 28);
    check_eq("hw_ready_lat_b", rise_b, 1);

    // Soft reset at S, then soft_req dropped; measure edges after S.
    step(1'b1, 1'b1, 1'b1);
    check_eq("soft_s_reset_o", int'(if_a.reset_o), 4'hF);
    rise_a = -1; rise_b = -1; ack_a = 0; ack_b = 0;
    for (int i = 1; i < 40; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (if_a.ready && rise_a < 0) begin rise_a = i; ack_a = int'(if_a.soft_ack); end
      if (if_b.ready && rise_b < 0) begin rise_b = i; ack_b = int'(if_b.soft_ack); end
    end
    check_eq("soft_ready_lat_a", rise_a, 29);
    check_eq("soft_ready_lat_b", rise_b, 2);
    check_eq("soft_ack_at_rise_a", ack_a, 1);
    check_eq("soft_ack_at_rise_b", ack_b, 1);

    // Reset pulled low mid-release, then a full restart.
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 23; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 35; i++) step(1'b1, 1'b0, 1'b0);

    // soft_req pulses during HOLD/RELEASE of the 4-domain instance.
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 28; i++) step(1'b1, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);

    // soft_req held high: back-to-back sequences.
    for (int i = 0; i < 130; i++) step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 35; i++) step(1'b1, 1'b0, 1'b0);

    // Random mix of hardware resets and soft requests.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        for (int j = 0; j < int'($urandom_range(1, 3)); j++) step(1'b0, 1'b1, 1'b1);
      end else begin
        step(1'b1, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
